// File: rtl/sha_pkg.sv
// Shared constants and state type for the SHA-2 message padder.
package sha_pkg;
  localparam int unsigned BLOCK_W        = 512;
  localparam int unsigned BLOCK_BYTES    = BLOCK_W / 8;
  localparam int unsigned DEFAULT_LEN_W  = 64;
  localparam logic [7:0]  PAD_BYTE       = 8'h80;
  localparam int unsigned MAX_TAIL_BYTES = 55;

  typedef enum logic [1:0] {
    ACCEPT,
    EMIT,
    EMIT_PAD,
    EMIT_LEN
  } pad_state_e;
endpackage

// File: rtl/sha_msg_padder_if.sv
// Word-in / block-out bus of the SHA padder; s_keep exists only under SHA_PAD_KEEP_EN.
interface sha_msg_padder_if #(
  parameter int unsigned IN_W = 32
) ();
  import sha_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [IN_W-1:0]     s_data;
  logic                s_last;
`ifdef SHA_PAD_KEEP_EN
  logic [IN_W/8-1:0]   s_keep;
`endif
  logic                m_valid;
  logic                m_ready;
  logic [BLOCK_W-1:0]  m_block;
  logic                m_first;
  logic                m_final;
  logic                busy;

`ifdef SHA_PAD_KEEP_EN
  modport master (
    output s_valid, s_data, s_last, s_keep, m_ready,
    input  s_ready, m_valid, m_block, m_first, m_final, busy
  );
  modport slave (
    input  s_valid, s_data, s_last, s_keep, m_ready,
    output s_ready, m_valid, m_block, m_first, m_final, busy
  );
`else
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_block, m_first, m_final, busy
  );
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_block, m_first, m_final, busy
  );
`endif
endinterface

// File: rtl/sha_pad_merge.sv
// Combinational tail padding: keeps byte_cnt bytes, appends 0x80, zero-fills,
// and inserts the bit length when it fits in the same block.
module sha_pad_merge
  import sha_pkg::*;
#(
  parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
  input  logic [BLOCK_W-1:0] blk_in,
  input  logic [6:0]         byte_cnt,
  input  logic [LEN_W-1:0]   bit_len,
  output logic [BLOCK_W-1:0] blk_out,
  output logic               needs_extra
);
  logic [31:0] cnt_ext;

  always_comb begin
    cnt_ext     = 32'(byte_cnt);
    needs_extra = cnt_ext > MAX_TAIL_BYTES;
    blk_out     = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (i < cnt_ext) begin
        blk_out[BLOCK_W-1-8*i -: 8] = blk_in[BLOCK_W-1-8*i -: 8];
      end else if (i == cnt_ext) begin
        blk_out[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
      end
    end
    if (!needs_extra) begin
      blk_out[LEN_W-1:0] = bit_len;
    end
  end
endmodule

// File: rtl/sha_msg_padder.sv
// SHA-2 message padder: packs IN_W-bit words into 512-bit blocks and appends
// 0x80 / zeros / bit length. Byte-granular last words under SHA_PAD_KEEP_EN.
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
  input logic             clk,
  input logic             reset,
  sha_msg_padder_if.slave bus
);
  localparam int unsigned WORDS      = BLOCK_W / IN_W;
  localparam int unsigned WORD_BYTES = IN_W / 8;
  localparam int unsigned PTR_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);

  pad_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic               m_first_q, m_first_d;
  logic               m_final_q, m_final_d;
  logic               busy_q, busy_d;
  logic               first_pend_q, first_pend_d;
  logic               pad_next_q, pad_next_d;

  logic [BLOCK_W-1:0] merged, padded, extra_blk;
  logic [6:0]         keep_bytes, word_bytes, byte_cnt;
  logic [LEN_W-1:0]   new_len;
  logic               needs_extra;
  logic               finish;

`ifdef SHA_PAD_KEEP_EN
  always_comb begin
    keep_bytes = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      keep_bytes = keep_bytes + 7'(bus.s_keep[i]);
    end
  end
`else
  assign keep_bytes = 7'(WORD_BYTES);
`endif

  assign word_bytes = bus.s_last ? keep_bytes : 7'(WORD_BYTES);
  assign byte_cnt   = 7'(32'(ptr_q) * WORD_BYTES) + word_bytes;
  assign new_len    = bit_cnt_q + (LEN_W'(word_bytes) << 3);

  always_comb begin
    merged = blk_q;
    merged[BLOCK_W-1 - 32'(ptr_q)*IN_W -: IN_W] = bus.s_data;
  end

  // Second block of a message: 0x80 leads only when the data filled block one.
  always_comb begin
    extra_blk            = '0;
    extra_blk[LEN_W-1:0] = bit_cnt_q;
    if (pad_next_q) begin
      extra_blk[BLOCK_W-1 -: 8] = PAD_BYTE;
    end
  end

  sha_pad_merge #(
    .LEN_W (LEN_W)
  ) u_merge (
    .blk_in      (merged),
    .byte_cnt    (byte_cnt),
    .bit_len     (new_len),
    .blk_out     (padded),
    .needs_extra (needs_extra)
  );

  // blk_q is both the word accumulator and the held output block; s_ready=0
  // in every EMIT state keeps the two roles from overlapping.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    bit_cnt_d    = bit_cnt_q;
    blk_d        = blk_q;
    m_valid_d    = m_valid_q;
    m_first_d    = m_first_q;
    m_final_d    = m_final_q;
    first_pend_d = first_pend_q;
    pad_next_d   = pad_next_q;
    finish       = 1'b0;

    unique case (state_q)
      ACCEPT: begin
        if (bus.s_valid && s_ready_q) begin
          bit_cnt_d = new_len;
          if (bus.s_last || (ptr_q == LAST_PTR)) begin
            m_valid_d    = 1'b1;
            m_first_d    = first_pend_q;
            first_pend_d = 1'b0;
            ptr_d        = '0;
            if (bus.s_last) begin
              blk_d      = padded;
              m_final_d  = !needs_extra;
              pad_next_d = (byte_cnt == 7'(BLOCK_BYTES));
              state_d    = EMIT_PAD;
            end else begin
              blk_d     = merged;
              m_final_d = 1'b0;
              state_d   = EMIT;
            end
          end else begin
            blk_d = merged;
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
      EMIT: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          m_first_d = 1'b0;
          blk_d     = '0;
          state_d   = ACCEPT;
        end
      end
      EMIT_PAD: begin
        if (bus.m_ready) begin
          if (m_final_q) begin
            finish = 1'b1;
          end else begin
            blk_d     = extra_blk;
            m_first_d = 1'b0;
            m_final_d = 1'b1;
            state_d   = EMIT_LEN;
          end
        end
      end
      EMIT_LEN: begin
        if (bus.m_ready) begin
          finish = 1'b1;
        end
      end
      default: ;
    endcase

    if (finish) begin
      state_d      = ACCEPT;
      ptr_d        = '0;
      m_valid_d    = 1'b0;
      m_first_d    = 1'b0;
      m_final_d    = 1'b0;
      blk_d        = '0;
      bit_cnt_d    = '0;
      first_pend_d = 1'b1;
      pad_next_d   = 1'b0;
    end

    s_ready_d = (state_d == ACCEPT);
    busy_d    = (state_d != ACCEPT) || (ptr_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ACCEPT;
      ptr_q        <= '0;
      bit_cnt_q    <= '0;
      blk_q        <= '0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_first_q    <= 1'b0;
      m_final_q    <= 1'b0;
      busy_q       <= 1'b0;
      first_pend_q <= 1'b1;
      pad_next_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      bit_cnt_q    <= bit_cnt_d;
      blk_q        <= blk_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_first_q    <= m_first_d;
      m_final_q    <= m_final_d;
      busy_q       <= busy_d;
      first_pend_q <= first_pend_d;
      pad_next_q   <= pad_next_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_block = blk_q;
  assign bus.m_first = m_first_q;
  assign bus.m_final = m_final_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder: 32-bit and 64-bit instances, reference padding of byte messages.
module tb_sha_msg_padder;
  import sha_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [BLOCK_W-1:0] blk0_seen;

  sha_msg_padder_if #(.IN_W(32)) if32 ();
  sha_msg_padder_if #(.IN_W(64)) if64 ();

  sha_msg_padder #(.IN_W(32), .LEN_W(64)) u_dut32 (.clk(clk), .reset(reset), .bus(if32));
  sha_msg_padder #(.IN_W(64), .LEN_W(64)) u_dut64 (.clk(clk), .reset(reset), .bus(if64));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_s_ready(input bit wide);
    return wide ? if64.s_ready : if32.s_ready;
  endfunction
  function automatic logic get_m_valid(input bit wide);
    return wide ? if64.m_valid : if32.m_valid;
  endfunction
  function automatic logic get_m_first(input bit wide);
    return wide ? if64.m_first : if32.m_first;
  endfunction
  function automatic logic get_m_final(input bit wide);
    return wide ? if64.m_final : if32.m_final;
  endfunction
  function automatic logic get_busy(input bit wide);
    return wide ? if64.busy : if32.busy;
  endfunction
  function automatic logic [BLOCK_W-1:0] get_m_block(input bit wide);
    return wide ? if64.m_block : if32.m_block;
  endfunction

  task automatic set_m_ready(input bit wide, input logic v);
    if (wide) if64.m_ready = v;
    else      if32.m_ready = v;
  endtask

`ifdef SHA_PAD_KEEP_EN
  task automatic drive_in(input bit wide, input logic v, input logic [63:0] d, input logic l, input logic [7:0] k);
    if (wide) begin
      if64.s_valid = v; if64.s_data = d; if64.s_last = l; if64.s_keep = k;
    end else begin
      if32.s_valid = v; if32.s_data = d[31:0]; if32.s_last = l; if32.s_keep = k[3:0];
    end
  endtask
`else
  task automatic drive_in(input bit wide, input logic v, input logic [63:0] d, input logic l);
    if (wide) begin
      if64.s_valid = v; if64.s_data = d; if64.s_last = l;
    end else begin
      if32.s_valid = v; if32.s_data = d[31:0]; if32.s_last = l;
    end
  endtask
`endif

  task automatic drive_idle(input bit wide);
`ifdef SHA_PAD_KEEP_EN
    drive_in(wide, 1'b0, '0, 1'b0, '0);
`else
    drive_in(wide, 1'b0, '0, 1'b0);
`endif
  endtask

  function automatic byte_q_t mk_msg(input int unsigned n, input logic [7:0] seed);
    byte_q_t q;
    for (int unsigned i = 0; i < n; i++) q.push_back(seed + 8'(i));
    return q;
  endfunction

  // Standard SHA-256 padding of a byte message.
  function automatic byte_q_t pad_ref(input byte_q_t m);
    byte_q_t     q;
    logic [63:0] len;
    q = m;
    q.push_back(8'h80);
    while ((q.size() % 64) != 56) q.push_back(8'h00);
    len = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) q.push_back(len[8*i +: 8]);
    return q;
  endfunction

  function automatic logic [BLOCK_W-1:0] exp_block(input byte_q_t p, input int unsigned k);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) r[BLOCK_W-1-8*i -: 8] = p[64*k + i];
    return r;
  endfunction

  task automatic send_word(input bit wide, input byte_q_t msg, input int unsigned w,
                           input logic last, input string tag);
    int unsigned wb;
    int unsigned n;
    logic [63:0] d;
`ifdef SHA_PAD_KEEP_EN
    logic [7:0]  k;
    k = '0;
`endif
    wb = wide ? 8 : 4;
    n  = 0;
    d  = '0;
    for (int unsigned i = 0; i < wb; i++) begin
      if (w*wb + i < msg.size()) begin
        d[(wb-1-i)*8 +: 8] = msg[w*wb + i];
`ifdef SHA_PAD_KEEP_EN
        k[wb-1-i] = 1'b1;
`endif
      end
    end
    @(negedge clk);
`ifdef SHA_PAD_KEEP_EN
    drive_in(wide, 1'b1, d, last, k);
`else
    drive_in(wide, 1'b1, d, last);
`endif
    while (!get_s_ready(wide) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!get_s_ready(wide)) check({tag, "_ready_timeout"}, get_s_ready(wide), 1'b1);
    @(posedge clk);
    #1;
    drive_idle(wide);
  endtask

  task automatic recv_block(input bit wide, input int unsigned stall, input logic [BLOCK_W-1:0] exp,
                            input logic exp_first, input logic exp_final, input string tag);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!get_m_valid(wide) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!get_m_valid(wide)) check({tag, "_valid_timeout"}, get_m_valid(wide), 1'b1);
    for (int unsigned s = 0; s < stall; s++) begin
      check({tag, "_stall_block"}, get_m_block(wide), exp);
      check({tag, "_stall_valid"}, get_m_valid(wide), 1'b1);
      check({tag, "_stall_sready"}, get_s_ready(wide), 1'b0);
      @(negedge clk);
    end
    check({tag, "_block"}, get_m_block(wide), exp);
    check({tag, "_first"}, get_m_first(wide), exp_first);
    check({tag, "_final"}, get_m_final(wide), exp_final);
    if (exp_first) blk0_seen = get_m_block(wide);
    set_m_ready(wide, 1'b1);
    @(posedge clk);
    #1;
    set_m_ready(wide, 1'b0);
    if (stall > 0) check({tag, "_stall_xfer"}, get_m_valid(wide), 1'b0);
  endtask

  task automatic run_msg(input string tag, input bit wide, input byte_q_t msg, input int unsigned stall);
    byte_q_t     p;
    int unsigned wb, nwords, nblk, blk;
    logic        last;
    p      = pad_ref(msg);
    nblk   = p.size() / 64;
    wb     = wide ? 8 : 4;
    nwords = (msg.size() == 0) ? 1 : (msg.size() + wb - 1) / wb;
    blk    = 0;
    for (int unsigned w = 0; w < nwords; w++) begin
      last = (w == nwords - 1);
      send_word(wide, msg, w, last, tag);
      if (last || (((w + 1) * wb) % 64 == 0)) begin
        check({tag, "_latency"}, get_m_valid(wide), 1'b1);
        if (last) begin
          while (blk < nblk) begin
            recv_block(wide, (blk == 0) ? stall : 0, exp_block(p, blk), blk == 0, blk == nblk - 1, tag);
            blk++;
          end
        end else begin
          recv_block(wide, (blk == 0) ? stall : 0, exp_block(p, blk), blk == 0, 1'b0, tag);
          blk++;
        end
      end
    end
    check({tag, "_idle_sready"}, get_s_ready(wide), 1'b1);
    check({tag, "_idle_busy"}, get_busy(wide), 1'b0);
  endtask

  initial begin
    byte_q_t m;
    drive_idle(1'b0);
    drive_idle(1'b1);
    set_m_ready(1'b0, 1'b0);
    set_m_ready(1'b1, 1'b0);
    blk0_seen = '0;

    repeat (3) @(negedge clk);
    check("rst_sready", if32.s_ready, 1'b0);
    check("rst_mvalid", if32.m_valid, 1'b0);
    check("rst_busy",   if32.busy,    1'b0);
    check("rst_first",  if32.m_first, 1'b0);
    check("rst_final",  if32.m_final, 1'b0);
    check("rst_block",  if32.m_block, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_sready", if32.s_ready, 1'b1);

    m = {8'h61, 8'h62, 8'h63, 8'h64};
    run_msg("abcd", 1'b0, m, 0);
    check("abcd_const", blk0_seen, {32'h61626364, 32'h80000000, 384'h0, 64'h20});

`ifdef SHA_PAD_KEEP_EN
    m = {8'h61, 8'h62, 8'h63};
    run_msg("abc", 1'b0, m, 0);
    check("abc_const", blk0_seen, {32'h61626380, 416'h0, 64'h18});
    m = {};
    run_msg("empty", 1'b0, m, 0);
    check("empty_const", blk0_seen, {8'h80, 504'h0});
    run_msg("len55", 1'b0, mk_msg(55, 8'h10), 0);
`endif

    run_msg("len52", 1'b0, mk_msg(52, 8'h20), 0);
    run_msg("len56", 1'b0, mk_msg(56, 8'h01), 0);
    run_msg("len64w", 1'b1, mk_msg(64, 8'h40), 0);
    run_msg("stall68", 1'b0, mk_msg(68, 8'h90), 5);

    m = mk_msg(64, 8'hA0);
    for (int unsigned w = 0; w < 7; w++) send_word(1'b0, m, w, 1'b0, "partial");
    check("partial_busy", if32.busy, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy",   if32.busy,    1'b0);
    check("midrst_sready", if32.s_ready, 1'b0);
    check("midrst_mvalid", if32.m_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_busy",   if32.busy,    1'b0);
    check("postrst_mvalid", if32.m_valid, 1'b0);
`ifdef SHA_PAD_KEEP_EN
    m = {8'h78, 8'h79, 8'h7A};
    run_msg("after_rst", 1'b0, m, 0);
    check("after_rst_const", blk0_seen, {32'h78797A80, 416'h0, 64'h18});
`else
    m = {8'h78, 8'h79, 8'h7A, 8'h21};
    run_msg("after_rst", 1'b0, m, 0);
    check("after_rst_const", blk0_seen, {32'h78797A21, 32'h80000000, 384'h0, 64'h20});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha_msg_padder.md
SHA_MSG_PADDER -- requirements
Module: sha_msg_padder

Interface
REQ-001 SHALL have parameter IN_W, default 32: input word width in bits; legal values 32, 64, 128, 256, 512.
REQ-002 SHALL have parameter LEN_W, default 64: width of the message bit-length field appended to the final block.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have s_valid, input, 1 bit: input word valid.
REQ-006 SHALL have s_ready, output, 1 bit: padder accepts the word this cycle.
REQ-007 SHALL have s_data, input, IN_W bits: message word, first message byte in the MSBs.
REQ-008 SHALL have s_last, input, 1 bit: this word ends the message.
REQ-009 SHALL have s_keep, input, IN_W/8 bits: byte enables for the last word; present only under SHA_PAD_KEEP_EN.
REQ-010 SHALL have m_valid, output, 1 bit: m_block holds a complete 512-bit block.
REQ-011 SHALL have m_ready, input, 1 bit: hash core takes the block this cycle.
REQ-012 SHALL have m_block, output, 512 bits: block, first word in bits [511:512-IN_W].
REQ-013 SHALL have m_first, output, 1 bit: block is the first of a message (hash core reloads its IV).
REQ-014 SHALL have m_final, output, 1 bit: block is the last of a message (digest valid after it).
REQ-015 SHALL have busy, output, 1 bit: a message is partially accepted or blocks are pending.

Function
REQ-016 SHALL implement FSM states ACCEPT, EMIT, EMIT_PAD and EMIT_LEN.
- ACCEPT: s_ready=1; each word is written at word pointer ptr; ptr increments 0..512/IN_W-1.
- Full block without s_last: go to EMIT.
- s_last: pad the block, then go to EMIT_PAD.
REQ-017 SHALL count message bits in a LEN_W-bit counter that wraps modulo 2^LEN_W; it clears after the final handshake.
REQ-018 SHALL pad on s_last as follows.
- Write byte 0x80 directly after the last valid byte, then zeros.
- If at most 55 message bytes are in the block: place the bit length in bits [63:0] and assert m_final.
- Otherwise: emit the block without a length; the next block (EMIT_LEN) is zeros plus the length.
REQ-019 SHALL handle a last word that fills the block exactly by emitting it non-final; the next block is 0x80, zeros and the length, with m_final=1.
REQ-020 SHALL assert m_valid on the cycle after the word completing a block is accepted (latency 1).
REQ-021 SHALL hold m_block, m_first and m_final stable while m_valid=1 and m_ready=0.
REQ-022 SHALL hold s_ready=0 in all EMIT states; transfers occur only when valid and ready are both 1.
REQ-023 SHALL return to ACCEPT with ptr=0 after the m_final handshake.
REQ-024 SHALL allow a new message to be accepted in the cycle after that handshake (no dead cycle beyond this).
REQ-025 SHALL set m_first=1 only on the first block emitted after reset or after an m_final handshake.
REQ-026 SHALL drive busy=0 only in ACCEPT with ptr=0 and no pending block.

Reset
REQ-027 SHALL, while reset=0, force the following values.
- State = ACCEPT.
- ptr, bit counter and block buffer = 0.
- m_valid, m_first, m_final, busy and s_ready = 0.
REQ-028 SHALL make s_ready registered, rising to 1 on the first clock after reset release.
REQ-029 SHALL discard a partial message or pending block when reset is asserted mid-operation; no block is emitted afterwards.

Configuration
REQ-030 SHALL support byte-granular last words when SHA_PAD_KEEP_EN is defined.
- s_keep must be MSB-contiguous.
- s_keep=0 with s_last marks an empty message, producing one block 0x80 followed by zeros and length 0.
REQ-031 SHALL, without SHA_PAD_KEEP_EN, omit s_keep; every word is full, and message length is a multiple of IN_W bits.

Structure
REQ-032 SHALL take the following from shared package sha_pkg.
- BLOCK_W=512, LEN_W default 64, PAD_BYTE=8'h80, MAX_TAIL_BYTES=55.
- The state enum type.
REQ-033 SHALL use one sub-module, sha_pad_merge: combinational; inputs are buffer, byte count and length; outputs are the padded block and a needs_extra flag.

Verification
REQ-034 SHALL pass: IN_W=32, KEEP_EN, word 0x61626300, keep=4'b1110, last -> one block 0x61626380, zeros, length 0x18; m_first=m_final=1.
REQ-035 SHALL pass: 56-byte message -> block 1 data+0x80+zeros, m_final=0; block 2 zeros + length 0x1C0, m_final=1.
REQ-036 SHALL pass: 64-byte message, IN_W=64 -> block 1 raw data; block 2 0x80, zeros, length 0x200; m_first only on block 1.
REQ-037 SHALL pass: m_ready held 0 for 5 cycles with m_valid=1 -> m_block unchanged, s_ready=0; block transfers on cycle 6.
REQ-038 SHALL pass: reset pulsed after 7 of 16 words -> busy=0; a following 3-byte message yields the correct single block with m_first=1.
REQ-039 SHALL pass: KEEP_EN, s_keep=0 with s_last -> block 0x80 followed by zeros, length 0, m_first=m_final=1.
